bank_xbar_rob: RTL and testbench
================================

BANK_XBAR_ROB -- requirements
Module: bank_xbar_rob

Interface
REQ-001 Parameter NUM_CH, default 3, number of xbar return channels.
REQ-002 Parameter ROB_DEPTH, default 8, reorder entries per channel, indexed by rob_num.
REQ-003 Parameter DATA_W, default 128, return data width.
REQ-004 clk_i  in  1  single clock; all state on rising edge.
REQ-005 rst_i  in  1  asynchronous, active-low reset.
REQ-006 sc_xbar_valid_i  in  1  SRAM-controller return beat valid.
REQ-007 sc_xbar_ready_o  out  1  block accepts the beat this cycle.
REQ-008 sc_xbar_channel_id_i  in  2  target channel, 0..NUM_CH-1.
REQ-009 sc_xbar_rob_num_i  in  3  ROB slot allocated by ISU.
REQ-010 sc_xbar_data_i  in  DATA_W  return data.
REQ-011 rob_xbar_valid_o  out  1  in-order return beat to xbar valid.
REQ-012 rob_xbar_ready_i  in  1  xbar accepts beat.
REQ-013 rob_xbar_channel_id_o  out  2  channel of output beat.
REQ-014 rob_xbar_rob_num_o  out  3  slot being released.
REQ-015 rob_xbar_data_o  out  DATA_W  data of output beat.
REQ-016 xbar_isu_credit_o  out  NUM_CH  one-cycle pulse per channel when its slot is released.

Function
REQ-017 Each channel SHALL hold ROB_DEPTH entries (valid bit + data) and a 3-bit head pointer.
REQ-018 sc_xbar_ready_o SHALL be 1 only when the addressed entry is invalid and channel_id < NUM_CH; combinational, no same-cycle bypass of a release.
REQ-019 On valid&ready the entry SHALL be written and marked valid at the next edge; earliest output is the following cycle (1-cycle latency).
REQ-020 A channel is eligible when entry[head] is valid; beats SHALL leave each channel strictly in rob_num order regardless of arrival order.
REQ-021 Arbitration among eligible channels SHALL be round-robin, starting from the channel after the last granted one.
REQ-022 While rob_xbar_valid_o=1 and rob_xbar_ready_i=0, grant and all output fields SHALL remain stable (grant lock); new eligibility cannot preempt.
REQ-023 On output handshake: entry[head] cleared, head incremented modulo ROB_DEPTH (7 wraps to 0), credit bit of that channel pulsed the next cycle, RR pointer updated.
REQ-024 Simultaneous input write and output release SHALL both complete in one cycle, including different slots of the same channel.
REQ-025 Throughput SHALL be one output beat per cycle when ready_i is held 1.
REQ-026 channel_id >= NUM_CH SHALL never be accepted (ready low); no state change.
REQ-027 A full channel (all 8 valid) SHALL keep accepting nothing for that channel while draining normally.

Reset
REQ-028 On rst_i low, asynchronously: all valid bits 0, heads 0, RR pointer to channel NUM_CH-1 (so channel 0 wins first), grant lock cleared.
REQ-029 Reset values: rob_xbar_valid_o 0, xbar_isu_credit_o 0, rob_xbar_channel_id_o 0, rob_xbar_rob_num_o 0, rob_xbar_data_o 0; sc_xbar_ready_o follows REQ-018 (1 for legal channel).
REQ-030 Reset mid-transfer SHALL drop all pending entries without emitting credits; data storage need not be reset.

Structure
REQ-031 NUM_CH, ROB_DEPTH, DATA_W and channel-id/rob-num widths SHALL live in shared package bank_pkg.
REQ-032 Per-channel storage, head pointer and eligibility SHALL be sub-module bank_xbar_rob_ch, instantiated NUM_CH times; arbiter and output mux in top.

Verification
REQ-033 Out-of-order: ch0 writes rob 2,1,0 with data A2,A1,A0, ready_i=1 -> outputs rob 0,1,2 data A0,A1,A2 on consecutive cycles, three credit pulses on bit 0.
REQ-034 RR fairness: ch0,ch1,ch2 each hold rob0..1 valid -> output order ch0,ch1,ch2,ch0,ch1,ch2.
REQ-035 Backpressure: ready_i=0 for 5 cycles with ch1 rob0 pending and ch0 becoming eligible -> outputs held ch1/rob0 stable, ch1 wins when ready_i rises.
REQ-036 Wrap/full: ch2 fills rob0..7, 9th write to rob0 -> ready_o=0; release rob0 -> write accepted, head wraps 7->0 after 8 releases.
REQ-037 Illegal channel 3 with valid_i=1 -> ready_o=0, no output, no credit.
REQ-038 Reset asserted with 4 entries pending -> valid_o 0 immediately, no credits, post-reset write ch0 rob0 emerges next cycle.

Source files
------------

// File: rtl/bank_pkg.sv
// Shared sizing for the bank return crossbar reorder buffer.
package bank_pkg;

  localparam int unsigned NUM_CH    = 3;
  localparam int unsigned ROB_DEPTH = 8;
  localparam int unsigned DATA_W    = 128;
  localparam int unsigned CH_W      = 2;
  localparam int unsigned ROB_W     = 3;

  // Advance a reorder index, wrapping at the configured depth.
  function automatic logic [ROB_W-1:0] rob_inc(input logic [ROB_W-1:0] idx,
                                               input int unsigned depth);
    if (32'(idx) == depth - 32'd1) return '0;
    return idx + ROB_W'(1);
  endfunction

endpackage

// File: rtl/bank_xbar_rob_ch.sv
// One return channel: slot storage, in-order head pointer and head eligibility.
module bank_xbar_rob_ch
  import bank_pkg::ROB_W, bank_pkg::rob_inc;
#(
  parameter int unsigned DEPTH = bank_pkg::ROB_DEPTH,
  parameter int unsigned WIDTH = bank_pkg::DATA_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [ROB_W-1:0] wr_idx_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rel_i,
  output logic             slot_free_o,
  output logic             head_valid_o,
  output logic [ROB_W-1:0] head_idx_o,
  output logic [WIDTH-1:0] head_data_o
);

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [ROB_W-1:0] head_q, head_d;
  logic [WIDTH-1:0] data_q [DEPTH];

  // Release and write never target the same slot: writes need a free slot.
  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    if (rel_i) begin
      valid_d[head_q] = 1'b0;
      head_d          = rob_inc(head_q, DEPTH);
    end
    if (wr_en_i) begin
      valid_d[wr_idx_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      head_q  <= '0;
    end else begin
      valid_q <= valid_d;
      head_q  <= head_d;
    end
  end

  // Payload storage is qualified by valid bits, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign slot_free_o  = ~valid_q[wr_idx_i];
  assign head_valid_o = valid_q[head_q];
  assign head_idx_o   = head_q;
  assign head_data_o  = data_q[head_q];

endmodule

// File: rtl/bank_xbar_rob.sv
// Per-channel reorder buffers with round-robin, grant-locked in-order return.
module bank_xbar_rob
  import bank_pkg::CH_W, bank_pkg::ROB_W;
#(
  parameter int unsigned NUM_CH    = bank_pkg::NUM_CH,
  parameter int unsigned ROB_DEPTH = bank_pkg::ROB_DEPTH,
  parameter int unsigned DATA_W    = bank_pkg::DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              sc_xbar_valid_i,
  output logic              sc_xbar_ready_o,
  input  logic [CH_W-1:0]   sc_xbar_channel_id_i,
  input  logic [ROB_W-1:0]  sc_xbar_rob_num_i,
  input  logic [DATA_W-1:0] sc_xbar_data_i,
  output logic              rob_xbar_valid_o,
  input  logic              rob_xbar_ready_i,
  output logic [CH_W-1:0]   rob_xbar_channel_id_o,
  output logic [ROB_W-1:0]  rob_xbar_rob_num_o,
  output logic [DATA_W-1:0] rob_xbar_data_o,
  output logic [NUM_CH-1:0] xbar_isu_credit_o
);

  logic [NUM_CH-1:0] wr_en, rel, slot_free, head_valid;
  logic [ROB_W-1:0]  head_idx  [NUM_CH];
  logic [DATA_W-1:0] head_data [NUM_CH];

  logic [CH_W-1:0]   rr_q, rr_d, lock_ch_q, lock_ch_d, grant_c, cand_c;
  logic              lock_q, lock_d, out_valid_c, hs_c;
  logic [NUM_CH-1:0] credit_q, credit_d;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    bank_xbar_rob_ch #(
      .DEPTH (ROB_DEPTH),
      .WIDTH (DATA_W)
    ) u_ch (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .wr_en_i      (wr_en[c]),
      .wr_idx_i     (sc_xbar_rob_num_i),
      .wr_data_i    (sc_xbar_data_i),
      .rel_i        (rel[c]),
      .slot_free_o  (slot_free[c]),
      .head_valid_o (head_valid[c]),
      .head_idx_o   (head_idx[c]),
      .head_data_o  (head_data[c])
    );
  end

  // Out-of-range channel ids match no instance and so are never ready.
  always_comb begin
    sc_xbar_ready_o = 1'b0;
    wr_en           = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (sc_xbar_channel_id_i == CH_W'(c)) begin
        sc_xbar_ready_o = slot_free[c];
        wr_en[c]        = sc_xbar_valid_i & slot_free[c];
      end
    end
  end

  // Round-robin search from the channel after the last grant, unless locked.
  always_comb begin
    grant_c     = lock_ch_q;
    out_valid_c = lock_q;
    cand_c      = '0;
    if (!lock_q) begin
      for (int unsigned k = 1; k <= NUM_CH; k++) begin
        cand_c = CH_W'((32'(rr_q) + k) % NUM_CH);
        if (!out_valid_c && head_valid[cand_c]) begin
          grant_c     = cand_c;
          out_valid_c = 1'b1;
        end
      end
    end
  end

  assign hs_c = out_valid_c & rob_xbar_ready_i;

  always_comb begin
    rob_xbar_valid_o      = out_valid_c;
    rob_xbar_channel_id_o = '0;
    rob_xbar_rob_num_o    = '0;
    rob_xbar_data_o       = '0;
    rel                   = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (out_valid_c && grant_c == CH_W'(c)) begin
        rob_xbar_channel_id_o = grant_c;
        rob_xbar_rob_num_o    = head_idx[c];
        rob_xbar_data_o       = head_data[c];
        rel[c]                = hs_c;
      end
    end
  end

  always_comb begin
    rr_d      = hs_c ? grant_c : rr_q;
    lock_d    = out_valid_c & ~rob_xbar_ready_i;
    lock_ch_d = lock_d ? grant_c : lock_ch_q;
    credit_d  = rel;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rr_q      <= CH_W'(NUM_CH - 1);
      lock_q    <= 1'b0;
      lock_ch_q <= '0;
      credit_q  <= '0;
    end else begin
      rr_q      <= rr_d;
      lock_q    <= lock_d;
      lock_ch_q <= lock_ch_d;
      credit_q  <= credit_d;
    end
  end

  assign xbar_isu_credit_o = credit_q;

endmodule

// File: tb/tb_bank_xbar_rob.sv
// Directed bench for bank_xbar_rob with a per-cycle reference model.
module tb_bank_xbar_rob;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         sc_xbar_valid_i;
  logic         sc_xbar_ready_o;
  logic [1:0]   sc_xbar_channel_id_i;
  logic [2:0]   sc_xbar_rob_num_i;
  logic [127:0] sc_xbar_data_i;
  logic         rob_xbar_valid_o;
  logic         rob_xbar_ready_i;
  logic [1:0]   rob_xbar_channel_id_o;
  logic [2:0]   rob_xbar_rob_num_o;
  logic [127:0] rob_xbar_data_o;
  logic [2:0]   xbar_isu_credit_o;

  bank_xbar_rob dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .sc_xbar_valid_i       (sc_xbar_valid_i),
    .sc_xbar_ready_o       (sc_xbar_ready_o),
    .sc_xbar_channel_id_i  (sc_xbar_channel_id_i),
    .sc_xbar_rob_num_i     (sc_xbar_rob_num_i),
    .sc_xbar_data_i        (sc_xbar_data_i),
    .rob_xbar_valid_o      (rob_xbar_valid_o),
    .rob_xbar_ready_i      (rob_xbar_ready_i),
    .rob_xbar_channel_id_o (rob_xbar_channel_id_o),
    .rob_xbar_rob_num_o    (rob_xbar_rob_num_o),
    .rob_xbar_data_o       (rob_xbar_data_o),
    .xbar_isu_credit_o     (xbar_isu_credit_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cyc_n = 0;
  int cred_cnt [3];

  typedef struct {
    int           ch;
    int           rob;
    logic [127:0] d;
    int           t;
  } obs_t;
  obs_t obs [$];

  // Reference state: slot occupancy/data per channel, next rob to release, last winner.
  bit           mv [3][8];
  logic [127:0] md [3][8];
  int           mhead [3];
  int           mlast;
  bit           mlock;
  int           mlock_ch;
  logic [2:0]   exp_credit;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", nm, $time, act, exp);
    end
  endtask

  function automatic int cred_sum();
    return cred_cnt[0] + cred_cnt[1] + cred_cnt[2];
  endfunction

  always @(negedge clk_i) begin : cmp
    int         g;
    bit         ev;
    bit         er;
    logic [2:0] nc;
    cyc_n++;
    for (int c = 0; c < 3; c++) if (xbar_isu_credit_o[c] === 1'b1) cred_cnt[c]++;
    if (rob_xbar_valid_o === 1'b1 && rob_xbar_ready_i)
      obs.push_back('{int'(rob_xbar_channel_id_o), int'(rob_xbar_rob_num_o), rob_xbar_data_o, cyc_n});
    if (!rst_i) begin
      for (int c = 0; c < 3; c++) begin
        mhead[c] = 0;
        for (int r = 0; r < 8; r++) mv[c][r] = 1'b0;
      end
      mlast = 2; mlock = 1'b0; mlock_ch = 0; exp_credit = '0;
      chk("m_rst_valid", rob_xbar_valid_o, 0);
      chk("m_rst_credit", xbar_isu_credit_o, 0);
    end else begin
      er = 1'b0;
      if (sc_xbar_channel_id_i < 2'd3) er = !mv[sc_xbar_channel_id_i][sc_xbar_rob_num_i];
      ev = 1'b0; g = 0;
      if (mlock) begin
        ev = 1'b1; g = mlock_ch;
      end else begin
        for (int k = 1; k <= 3; k++) begin
          if (!ev && mv[(mlast + k) % 3][mhead[(mlast + k) % 3]]) begin
            ev = 1'b1; g = (mlast + k) % 3;
          end
        end
      end
      chk("m_ready", sc_xbar_ready_o, er);
      chk("m_valid", rob_xbar_valid_o, ev);
      if (ev) begin
        chk("m_ch", rob_xbar_channel_id_o, g);
        chk("m_rob", rob_xbar_rob_num_o, mhead[g]);
        chk("m_data", rob_xbar_data_o, md[g][mhead[g]]);
      end else begin
        chk("m_ch_idle", rob_xbar_channel_id_o, 0);
        chk("m_rob_idle", rob_xbar_rob_num_o, 0);
        chk("m_data_idle", rob_xbar_data_o, 0);
      end
      chk("m_credit", xbar_isu_credit_o, exp_credit);
      nc = '0;
      if (ev && rob_xbar_ready_i) begin
        mv[g][mhead[g]] = 1'b0;
        mhead[g] = (mhead[g] + 1) % 8;
        mlast = g; nc[g] = 1'b1; mlock = 1'b0;
      end else if (ev) begin
        mlock = 1'b1; mlock_ch = g;
      end else begin
        mlock = 1'b0;
      end
      if (sc_xbar_valid_i && er) begin
        mv[sc_xbar_channel_id_i][sc_xbar_rob_num_i] = 1'b1;
        md[sc_xbar_channel_id_i][sc_xbar_rob_num_i] = sc_xbar_data_i;
      end
      exp_credit = nc;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic wr(input int ch, input int rob, input logic [127:0] d);
    sc_xbar_valid_i      = 1'b1;
    sc_xbar_channel_id_i = 2'(ch);
    sc_xbar_rob_num_i    = 3'(rob);
    sc_xbar_data_i       = d;
    cyc(1);
    sc_xbar_valid_i      = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    cyc(2);
    rst_i = 1'b1;
  endtask

  task automatic chk_obs(input int i, input int ch, input int rob, input logic [127:0] d);
    if (i >= obs.size()) begin
      total++; bad++;
      $display("FAIL obs_missing idx=%0d actual_size=%0d", i, obs.size());
    end else begin
      chk($sformatf("obs%0d_ch", i), obs[i].ch, ch);
      chk($sformatf("obs%0d_rob", i), obs[i].rob, rob);
      chk($sformatf("obs%0d_data", i), obs[i].d, d);
    end
  endtask

  int e_ch  [6] = '{0, 1, 2, 0, 1, 2};
  int e_rob [6] = '{0, 0, 0, 1, 1, 1};
  int snap;

  initial begin
    rst_i = 1'b0; sc_xbar_valid_i = 1'b0; sc_xbar_channel_id_i = '0;
    sc_xbar_rob_num_i = '0; sc_xbar_data_i = '0; rob_xbar_ready_i = 1'b0;
    cyc(2);
    chk("rst_valid", rob_xbar_valid_o, 0);
    chk("rst_credit", xbar_isu_credit_o, 0);
    chk("rst_ch", rob_xbar_channel_id_o, 0);
    chk("rst_rob", rob_xbar_rob_num_o, 0);
    chk("rst_data", rob_xbar_data_o, 0);
    chk("rst_ready", sc_xbar_ready_o, 1);
    rst_i = 1'b1;

    // Out-of-order arrival on channel 0 drains in rob order.
    rob_xbar_ready_i = 1'b1; obs.delete(); snap = cred_cnt[0];
    wr(0, 2, 128'hA2); wr(0, 1, 128'hA1); wr(0, 0, 128'hA0);
    chk("ooo_first_valid", rob_xbar_valid_o, 1);
    cyc(5);
    chk("ooo_count", obs.size(), 3);
    chk_obs(0, 0, 0, 128'hA0); chk_obs(1, 0, 1, 128'hA1); chk_obs(2, 0, 2, 128'hA2);
    if (obs.size() == 3) chk("ooo_back_to_back", obs[2].t - obs[0].t, 2);
    chk("ooo_credits", cred_cnt[0] - snap, 3);

    // Round-robin across three loaded channels.
    do_reset(); rob_xbar_ready_i = 1'b0; obs.delete();
    for (int c = 0; c < 3; c++)
      for (int r = 0; r < 2; r++) wr(c, r, 128'h300 + 128'(16 * c + r));
    rob_xbar_ready_i = 1'b1;
    cyc(8);
    chk("rr_count", obs.size(), 6);
    for (int i = 0; i < 6; i++) chk_obs(i, e_ch[i], e_rob[i], 128'h300 + 128'(16 * e_ch[i] + e_rob[i]));

    // Backpressure holds ch1 even after ch0 (higher RR priority) becomes eligible.
    do_reset(); rob_xbar_ready_i = 1'b0; obs.delete();
    wr(1, 0, 128'hB0); wr(0, 0, 128'hC0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rob_xbar_valid_o, 1);
      chk("bp_ch", rob_xbar_channel_id_o, 1);
      chk("bp_rob", rob_xbar_rob_num_o, 0);
      cyc(1);
    end
    rob_xbar_ready_i = 1'b1;
    cyc(4);
    chk("bp_count", obs.size(), 2);
    chk_obs(0, 1, 0, 128'hB0); chk_obs(1, 0, 0, 128'hC0);

    // Full channel 2, refill of rob0 after its release, head wraps 7 -> 0.
    do_reset(); rob_xbar_ready_i = 1'b0; obs.delete(); snap = cred_cnt[2];
    for (int r = 0; r < 8; r++) wr(2, r, 128'h2000 + 128'(r));
    sc_xbar_valid_i = 1'b1; sc_xbar_channel_id_i = 2'd2; sc_xbar_rob_num_i = 3'd0;
    sc_xbar_data_i = 128'h2F00;
    #1 chk("full_ready", sc_xbar_ready_o, 0);
    rob_xbar_ready_i = 1'b1;
    cyc(1);
    rob_xbar_ready_i = 1'b0;
    #1 chk("refill_ready", sc_xbar_ready_o, 1);
    cyc(1);
    sc_xbar_valid_i = 1'b0; rob_xbar_ready_i = 1'b1;
    cyc(12);
    chk("wrap_count", obs.size(), 9);
    for (int r = 0; r < 8; r++) chk_obs(r, 2, r, 128'h2000 + 128'(r));
    chk_obs(8, 2, 0, 128'h2F00);
    if (obs.size() == 9) chk("wrap_throughput", obs[8].t - obs[1].t, 7);
    chk("wrap_credits", cred_cnt[2] - snap, 9);

    // Illegal channel id is never accepted.
    obs.delete(); snap = cred_sum();
    sc_xbar_valid_i = 1'b1; sc_xbar_channel_id_i = 2'd3; sc_xbar_rob_num_i = 3'd0;
    sc_xbar_data_i = 128'hDEAD;
    #1 chk("illegal_ready", sc_xbar_ready_o, 0);
    cyc(3);
    chk("illegal_valid", rob_xbar_valid_o, 0);
    sc_xbar_valid_i = 1'b0;
    cyc(2);
    chk("illegal_no_out", obs.size(), 0);
    chk("illegal_no_credit", cred_sum() - snap, 0);

    // Reset with entries pending drops them without credits.
    rob_xbar_ready_i = 1'b0; obs.delete();
    wr(0, 0, 128'h1); wr(1, 0, 128'h2); wr(0, 1, 128'h3); wr(2, 1, 128'h4);
    snap = cred_sum();
    #2 rst_i = 1'b0;
    #1 chk("midrst_valid", rob_xbar_valid_o, 0);
    chk("midrst_credit", xbar_isu_credit_o, 0);
    cyc(1);
    rst_i = 1'b1; rob_xbar_ready_i = 1'b1;
    wr(0, 0, 128'hE0);
    chk("postrst_valid", rob_xbar_valid_o, 1);
    chk("postrst_ch", rob_xbar_channel_id_o, 0);
    chk("postrst_rob", rob_xbar_rob_num_o, 0);
    chk("postrst_data", rob_xbar_data_o, 128'hE0);
    cyc(3);
    chk("postrst_credits", cred_sum() - snap, 1);
    chk("postrst_count", obs.size(), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
